// File: rtl/edf_heap_queue.sv
// Earliest-deadline-first priority queue: binary min-heap held in a register array,
// moving one heap level per clock, with FIFO order between equal labels via arrival stamps.
module edf_heap_queue #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 16,
  parameter int LABEL_WIDTH  = 8,
  parameter int WRAP_COMPARE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int SW    = ADDR_WIDTH + 1;
  localparam int EW    = DATA_WIDTH + SW;
  localparam int LW    = LABEL_WIDTH;

  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

  state_t                r_state;
  logic [EW-1:0]         r_mem [DEPTH];
  logic [EW-1:0]         r_hold;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH:0]   r_count;
  logic [SW-1:0]         r_wrSeq;

  // Labels decide first; equal labels fall back to age, where a larger age is older.
  function automatic logic entryBefore(
    input logic [LW-1:0] la,
    input logic [SW-1:0] sa,
    input logic [LW-1:0] lb,
    input logic [SW-1:0] sb,
    input logic [SW-1:0] seq
  );
    logic [LW-1:0] diff;
    logic [SW-1:0] ageA;
    logic [SW-1:0] ageB;
    diff = la - lb;
    ageA = seq - sa;
    ageB = seq - sb;
    if (la != lb) begin
      if (WRAP_COMPARE != 0) entryBefore = diff[LW-1];
      else                   entryBefore = la < lb;
    end else begin
      entryBefore = ageA > ageB;
    end
  endfunction

  logic w_idle;
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic [ADDR_WIDTH-1:0] w_lastIdx;

  assign w_idle    = (r_state == IDLE);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (ADDR_WIDTH+1)'(DEPTH));
  assign w_lastIdx = r_count[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  assign in_ready  = !rst && w_idle && (!w_full || out_ready);
  assign out_valid = !rst && w_idle && !w_empty;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_data  = out_valid ? r_mem[0][EW-1:SW] : '0;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign busy      = !w_idle;

  logic [ADDR_WIDTH-1:0] w_parent;
  logic [EW-1:0]         w_parentEntry;
  logic                  w_upMove;

  assign w_parent      = (r_idx - ADDR_WIDTH'(1)) >> 1;
  assign w_parentEntry = r_mem[w_parent];
  assign w_upMove      = (r_idx != '0) &&
                         entryBefore(r_hold[EW-1 -: LW], r_hold[SW-1:0],
                                     w_parentEntry[EW-1 -: LW], w_parentEntry[SW-1:0], r_wrSeq);

  // Child indices are one bit wider than idx so that 2*idx+2 never wraps before the existence test.
  logic [ADDR_WIDTH+1:0] w_left;
  logic [ADDR_WIDTH+1:0] w_right;
  logic [ADDR_WIDTH-1:0] w_leftIdx;
  logic [ADDR_WIDTH-1:0] w_rightIdx;
  logic [ADDR_WIDTH-1:0] w_child;
  logic [EW-1:0]         w_leftEntry;
  logic [EW-1:0]         w_rightEntry;
  logic [EW-1:0]         w_childEntry;
  logic                  w_leftExists;
  logic                  w_rightExists;
  logic                  w_pickRight;
  logic                  w_downMove;

  assign w_left        = {1'b0, r_idx, 1'b1};
  assign w_right       = w_left + (ADDR_WIDTH+2)'(1);
  assign w_leftExists  = w_left  < {1'b0, r_count};
  assign w_rightExists = w_right < {1'b0, r_count};
  assign w_leftIdx     = w_left[ADDR_WIDTH-1:0];
  assign w_rightIdx    = w_right[ADDR_WIDTH-1:0];
  assign w_leftEntry   = r_mem[w_leftIdx];
  assign w_rightEntry  = r_mem[w_rightIdx];
  assign w_pickRight   = w_rightExists &&
                         entryBefore(w_rightEntry[EW-1 -: LW], w_rightEntry[SW-1:0],
                                     w_leftEntry[EW-1 -: LW], w_leftEntry[SW-1:0], r_wrSeq);
  assign w_child       = w_pickRight ? w_rightIdx : w_leftIdx;
  assign w_childEntry  = w_pickRight ? w_rightEntry : w_leftEntry;
  assign w_downMove    = w_leftExists &&
                         entryBefore(w_childEntry[EW-1 -: LW], w_childEntry[SW-1:0],
                                     r_hold[EW-1 -: LW], r_hold[SW-1:0], r_wrSeq);

  // Every sift cycle writes the current slot: either the displaced neighbour or the held entry.
  logic                  w_memWe;
  logic [ADDR_WIDTH-1:0] w_memAddr;
  logic [EW-1:0]         w_memData;

  always_comb begin
    w_memWe   = 1'b0;
    w_memAddr = r_idx;
    w_memData = r_hold;
    case (r_state)
      SIFT_UP: begin
        w_memWe = 1'b1;
        if (w_upMove) w_memData = w_parentEntry;
      end
      SIFT_DOWN: begin
        w_memWe = 1'b1;
        if (w_downMove) w_memData = w_childEntry;
      end
      default: begin
        w_memWe = 1'b0;
      end
    endcase
    if (rst) w_memWe = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_memWe) r_mem[w_memAddr] <= w_memData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_wrSeq <= '0;
      r_idx   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_push) r_wrSeq <= r_wrSeq + SW'(1);
          if (w_push && w_pop) begin
            r_hold  <= {in_data, r_wrSeq};
            r_idx   <= '0;
            r_state <= SIFT_DOWN;
          end else if (w_push) begin
            r_hold  <= {in_data, r_wrSeq};
            r_idx   <= r_count[ADDR_WIDTH-1:0];
            r_count <= r_count + (ADDR_WIDTH+1)'(1);
            r_state <= SIFT_UP;
          end else if (w_pop) begin
            r_count <= r_count - (ADDR_WIDTH+1)'(1);
            if (r_count != (ADDR_WIDTH+1)'(1)) begin
              r_hold  <= r_mem[w_lastIdx];
              r_idx   <= '0;
              r_state <= SIFT_DOWN;
            end
          end
        end
        SIFT_UP: begin
          if (w_upMove) r_idx   <= w_parent;
          else          r_state <= IDLE;
        end
        SIFT_DOWN: begin
          if (w_downMove) r_idx   <= w_child;
          else            r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edf_heap_queue.sv
// Randomised and directed bench for edf_heap_queue against an insertion-ordered list model
// whose head is the earliest-inserted entry with the smallest wrap-compared label.
module tb_edf_heap_queue;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int LW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inData;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outData;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          busy;

  int nChecks = 0;
  int nErrors = 0;
  int phasePushes = 0;
  logic [DW-1:0] model[$];

  always #5 clk = ~clk;

  edf_heap_queue #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LABEL_WIDTH(LW),
    .WRAP_COMPARE(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(inValid),
    .in_ready(inReady),
    .in_data(inData),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_data(outData),
    .count(count),
    .empty(empty),
    .full(full),
    .busy(busy)
  );

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic bit labelBefore(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [LW-1:0] d;
    d = a - b;
    return d[LW-1];
  endfunction

  function automatic int headIdx();
    int best = 0;
    for (int i = 1; i < model.size(); i++)
      if (labelBefore(model[i][DW-1 -: LW], model[best][DW-1 -: LW])) best = i;
    return best;
  endfunction

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r,
                               output bit pushed, output bit popped, output logic [DW-1:0] popData);
    inValid  = v;
    inData   = d;
    outReady = r;
    #1;
    pushed  = inValid && inReady;
    popped  = outValid && outReady;
    popData = outData;
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    outReady = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (busy !== 1'b0) checkOutput("idleTimeout", busy, 0);
  endtask

  task automatic checkState();
    checkOutput("count", count, model.size());
    checkOutput("empty", empty, model.size() == 0);
    checkOutput("full", full, model.size() == DEPTH);
    checkOutput("outValid", outValid, model.size() != 0);
    if (model.size() != 0) checkOutput("head", outData, model[headIdx()]);
    else                   checkOutput("headZero", outData, 0);
  endtask

  task automatic doOp(input logic v, input logic [DW-1:0] d, input logic r, output logic [DW-1:0] popData);
    bit pushed, popped, expPushed, expPopped;
    int cyc, h;
    expPushed = v && ((model.size() < DEPTH) || r);
    expPopped = r && (model.size() > 0);
    applyStimulus(v, d, r, pushed, popped, popData);
    checkOutput("pushAccept", pushed, expPushed);
    checkOutput("popAccept", popped, expPopped);
    if (expPopped) begin
      h = headIdx();
      checkOutput("popData", popData, model[h]);
      model.delete(h);
    end
    if (expPushed) begin
      model.push_back(d);
      phasePushes++;
    end
    waitIdle(cyc);
    checkOutput("busyBound", cyc > AW + 1, 0);
    checkState();
  endtask

  logic [DW-1:0] got;
  logic [7:0]    labs[5]   = '{8'h30, 8'h10, 8'h20, 8'h05, 8'h40};
  logic [7:0]    sorted[5] = '{8'h05, 8'h10, 8'h20, 8'h30, 8'h40};
  logic [DW-1:0] ties[3]   = '{16'h0701, 16'h0702, 16'h0703};
  logic [7:0]    base;
  logic [7:0]    lab;
  logic          v, r;
  bit            pu, po;

  initial begin
    rst = 1'b1; inValid = 1'b0; inData = '0; outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstInReady", inReady, 0);
    checkOutput("rstOutValid", outValid, 0);
    rst = 1'b0; outReady = 1'b0;
    #1;
    checkOutput("postRstInReady", inReady, 1);
    checkOutput("postRstBusy", busy, 0);
    checkState();

    $display("[TB] heap order");
    for (int i = 0; i < 5; i++) doOp(1'b1, {labs[i], 8'(i)}, 1'b0, got);
    for (int i = 0; i < 5; i++) begin
      doOp(1'b0, '0, 1'b1, got);
      checkOutput("orderLabel", got[15:8], sorted[i]);
    end

    $display("[TB] tie stability");
    for (int i = 0; i < 3; i++) doOp(1'b1, ties[i], 1'b0, got);
    for (int i = 0; i < 3; i++) begin
      doOp(1'b0, '0, 1'b1, got);
      checkOutput("tieOrder", got, ties[i]);
    end

    $display("[TB] wrap compare");
    doOp(1'b1, 16'hF001, 1'b0, got);
    doOp(1'b1, 16'h0502, 1'b0, got);
    checkOutput("wrapHead", outData[15:8], 8'hF0);
    doOp(1'b0, '0, 1'b1, got);
    doOp(1'b0, '0, 1'b1, got);

    $display("[TB] full and replace-top");
    for (int i = 0; i < DEPTH; i++) doOp(1'b1, {8'(i + 1), 8'(i)}, 1'b0, got);
    inValid = 1'b1; inData = 16'h00BB; outReady = 1'b0;
    #1;
    checkOutput("fullFlag", full, 1);
    checkOutput("fullInReady", inReady, 0);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("fullHold", count, DEPTH);
    doOp(1'b1, 16'h00AA, 1'b1, got);
    checkOutput("replaceOld", got, 16'h0100);
    checkOutput("replaceCount", count, DEPTH);
    checkOutput("replaceHead", outData, 16'h00AA);
    while (model.size() > 0) doOp(1'b0, '0, 1'b1, got);

    $display("[TB] busy backpressure");
    for (int i = 0; i < 6; i++) doOp(1'b1, {8'(8'h50 + i), 8'h00}, 1'b0, got);
    applyStimulus(1'b1, 16'h4000, 1'b0, pu, po, got);
    checkOutput("bpAccept", pu, 1);
    model.push_back(16'h4000);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bpBusy", busy, 1);
      checkOutput("bpInReady", inReady, 0);
      @(posedge clk);
      #1;
    end
    checkOutput("bpDone", busy, 0);
    checkState();
    while (model.size() > 0) doOp(1'b0, '0, 1'b1, got);

    $display("[TB] reset mid-sift");
    for (int i = 0; i < 5; i++) doOp(1'b1, {8'(8'h60 + i), 8'h00}, 1'b0, got);
    applyStimulus(1'b0, '0, 1'b1, pu, po, got);
    checkOutput("rsPop", got, model[headIdx()]);
    model.delete(headIdx());
    checkOutput("rsSifting", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model.delete();
    checkOutput("rsCount", count, 0);
    checkOutput("rsOutValid", outValid, 0);
    checkOutput("rsBusy", busy, 0);
    doOp(1'b1, 16'h1122, 1'b0, got);
    doOp(1'b0, '0, 1'b1, got);
    checkOutput("rsAfter", got[15:8], 8'h11);

    $display("[TB] random traffic");
    for (int ph = 0; ph < 8; ph++) begin
      base = 8'($urandom);
      phasePushes = 0;
      for (int k = 0; k < 60; k++) begin
        v   = ($urandom_range(0, 2) != 0) && (phasePushes < 50);
        r   = ($urandom_range(0, 2) == 0);
        lab = base + 8'($urandom_range(0, 63));
        doOp(v, {lab, 8'($urandom)}, r, got);
      end
      while (model.size() > 0) doOp(1'b0, '0, 1'b1, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
